// File: rtl/rv32i_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core: FSM state
// encoding, major opcodes, ALUOp and datapath mux select codes, plus the
// opcode legality check and the EXEC-state ALU operand decode.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [1:0] ALU_A_RS1  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;

  // ALU operand selection and operation driven during EXEC.
  typedef struct packed {
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
  } exec_ctrl_t;

  function automatic logic opcode_is_legal(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic exec_ctrl_t exec_decode(input logic [6:0] op);
    exec_ctrl_t c;
    c = '{alu_src_a: ALU_A_RS1, alu_src_b: ALU_B_IMM, alu_op: ALUOP_ADD};
    case (op)
      OPC_OP:            c = '{alu_src_a: ALU_A_RS1,  alu_src_b: ALU_B_RS2, alu_op: ALUOP_FUNCT};
      OPC_OP_IMM:        c = '{alu_src_a: ALU_A_RS1,  alu_src_b: ALU_B_IMM, alu_op: ALUOP_FUNCT};
      OPC_AUIPC, OPC_JAL: c = '{alu_src_a: ALU_A_PC,  alu_src_b: ALU_B_IMM, alu_op: ALUOP_ADD};
      OPC_LUI:           c = '{alu_src_a: ALU_A_ZERO, alu_src_b: ALU_B_IMM, alu_op: ALUOP_LUI};
      OPC_BRANCH:        c = '{alu_src_a: ALU_A_RS1,  alu_src_b: ALU_B_RS2, alu_op: ALUOP_SUB};
      default:           c = '{alu_src_a: ALU_A_RS1,  alu_src_b: ALU_B_IMM, alu_op: ALUOP_ADD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcc_mem_timer.sv
// Memory wait-state watchdog. Counts cycles in which a request is pending
// without completion; the count restarts whenever no request is pending or
// a request completes, which makes it start from zero on every entry to
// FETCH or MEM. o_timeout flags the cycle in which the count would reach
// MEM_TIMEOUT; a completion in that same cycle suppresses the flag.
module mcc_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter: cleared when idle or on completion, else counts up.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // is sampled like any other input.
    if (reset || !i_req || i_ready) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_timeout = i_req && !i_ready && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath muxes,
// write enables and the memory request handshake, and traps on illegal
// opcodes or memory timeouts.
// Optional feature: define MCC_PERF_CNT_EN to add cycle_cnt/instret_cnt.
// Control outputs are registered together with the state. The only
// exceptions are the strobes qualified by a same-cycle input: ir_we and the
// STORE pc_we follow mem_ready, and the BRANCH pc_src follows branch_taken.
// After reset the FSM sits one cycle in FETCH with mem_req low before
// issuing the first fetch.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       illegal,
  output logic       mem_err
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  import rv32i_ctrl_pkg::*;

  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e     r_state;
  logic       r_mem_req;
  logic       r_mem_we;
  logic       r_mem_addr_sel;
  logic       r_pc_we;
  logic [1:0] r_pc_src;
  logic       r_br_exec;
  logic       r_reg_we;
  logic [1:0] r_wb_sel;
  logic [1:0] r_alu_src_a;
  logic       r_alu_src_b;
  logic [1:0] r_alu_op;
  logic       r_illegal;
  logic       r_mem_err;

  logic       w_timeout;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_is_jump;
  logic       w_store_done;
  exec_ctrl_t w_exec;

  assign w_is_load   = (opcode == OPC_LOAD);
  assign w_is_store  = (opcode == OPC_STORE);
  assign w_is_branch = (opcode == OPC_BRANCH);
  assign w_is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign w_exec      = exec_decode(opcode);

  mcc_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk      (clk),
    .reset    (reset),
    .i_req    (r_mem_req),
    .i_ready  (mem_ready),
    .o_timeout(w_timeout)
  );

  // State register plus registered control outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_FETCH;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr_sel <= 1'b0;
      r_pc_we        <= 1'b0;
      r_pc_src       <= PC_SRC_PLUS4;
      r_br_exec      <= 1'b0;
      r_reg_we       <= 1'b0;
      r_wb_sel       <= WB_SEL_ALU;
      r_alu_src_a    <= ALU_A_RS1;
      r_alu_src_b    <= ALU_B_RS2;
      r_alu_op       <= ALUOP_ADD;
      r_illegal      <= 1'b0;
      r_mem_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by per-state overrides; the last
      // assignment wins at the edge, and every control drops unless the
      // next state asks for it.
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr_sel <= 1'b0;
      r_pc_we        <= 1'b0;
      r_pc_src       <= PC_SRC_PLUS4;
      r_br_exec      <= 1'b0;
      r_reg_we       <= 1'b0;
      r_wb_sel       <= WB_SEL_ALU;
      r_alu_src_a    <= ALU_A_RS1;
      r_alu_src_b    <= ALU_B_RS2;
      r_alu_op       <= ALUOP_ADD;

      case (r_state)
        ST_FETCH: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;            // first fetch after reset
          end else if (mem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_timeout) begin
            r_state   <= ST_TRAP;
            r_mem_err <= 1'b1;
          end else begin
            r_mem_req <= 1'b1;
          end
        end

        ST_DECODE: begin
          if (opcode_is_legal(opcode)) begin
            r_state     <= ST_EXEC;
            r_alu_src_a <= w_exec.alu_src_a;
            r_alu_src_b <= w_exec.alu_src_b;
            r_alu_op    <= w_exec.alu_op;
            if (w_is_branch) begin
              r_pc_we   <= 1'b1;
              r_br_exec <= 1'b1;
            end
          end else begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (w_is_branch) begin
            r_state   <= ST_FETCH;
            r_mem_req <= 1'b1;
          end else if (w_is_load || w_is_store) begin
            r_state        <= ST_MEM;
            r_mem_req      <= 1'b1;
            r_mem_addr_sel <= 1'b1;
            r_mem_we       <= w_is_store;
          end else begin
            r_state  <= ST_WB;
            r_reg_we <= 1'b1;
            r_pc_we  <= 1'b1;
            r_wb_sel <= w_is_jump ? WB_SEL_PC4 : WB_SEL_ALU;
            r_pc_src <= w_is_jump ? PC_SRC_JUMP : PC_SRC_PLUS4;
          end
        end

        ST_MEM: begin
          if (mem_ready) begin
            if (w_is_store) begin
              r_state   <= ST_FETCH;
              r_mem_req <= 1'b1;
            end else begin
              r_state  <= ST_WB;
              r_reg_we <= 1'b1;
              r_pc_we  <= 1'b1;
              r_wb_sel <= WB_SEL_LOAD;
            end
          end else if (w_timeout) begin
            r_state   <= ST_TRAP;
            r_mem_err <= 1'b1;
          end else begin
            r_mem_req      <= 1'b1;
            r_mem_addr_sel <= 1'b1;
            r_mem_we       <= w_is_store;
          end
        end

        ST_WB: begin
          r_state   <= ST_FETCH;
          r_mem_req <= 1'b1;
        end

        ST_TRAP: r_state <= ST_TRAP;

        default: r_state <= ST_TRAP;
      endcase
    end
  end

  // A store retires on the cycle its memory write completes.
  assign w_store_done = (r_state == ST_MEM) && r_mem_we && mem_ready;

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr_sel = r_mem_addr_sel;
  assign ir_we        = (r_state == ST_FETCH) && r_mem_req && mem_ready;
  assign pc_we        = r_pc_we || w_store_done;
  assign pc_src       = r_br_exec ? {1'b0, branch_taken} : r_pc_src;
  assign reg_we       = r_reg_we;
  assign wb_sel       = r_wb_sel;
  assign alu_src_a    = r_alu_src_a;
  assign alu_src_b    = r_alu_src_b;
  assign ALUOp1       = r_alu_op[1];
  assign ALUOp0       = r_alu_op[0];
  assign illegal      = r_illegal;
  assign mem_err      = r_mem_err;

`ifdef MCC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // Cycle counter: advances every cycle outside TRAP, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
    end else if (r_state != ST_TRAP) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  // Retired-instruction counter: one PC update per instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret_cnt <= '0;
    end else if (pc_we) begin
      r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
